// File: rtl/button_conditioner.sv
// Synchronises and debounces the pet-FSM buttons, emits press pulses and runs the long-press test mode.
// Define BTN_AUTOREPEAT_EN to make feed/play re-pulse every REPEAT_CYCLES while held.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 250000000,
  parameter int SEL_MAX           = 9,
  parameter int HOLD_CYCLES       = 50,
  parameter int REPEAT_CYCLES     = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_sleep_n,
  input  logic       btn_awake_n,
  input  logic       btn_feed_n,
  input  logic       btn_play_n,
  input  logic       btn_test_n,
  input  logic       giro_raw,
  output logic       botonSleep,
  output logic       botonAwake,
  output logic       botonFeed,
  output logic       botonPlay,
  output logic       giro,
  output logic       botonTest,
  output logic [3:0] BpulseTest
);

  localparam int NIN = 6;
  localparam int DW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int LW  = $clog2(LONG_PRESS_CYCLES + 1);
  localparam int HW  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [2:0] {
    T_OFF,
    T_ENTER_WAIT,
    T_SEL,
    T_EXIT,
    T_EXIT_WAIT
  } t_state_e;

  logic [NIN-1:0] w_raw;
  logic [NIN-1:0] r_sync1;
  logic [NIN-1:0] r_sync2;
  logic [NIN-1:0] w_deb;
  logic [3:0]     r_deb_d;
  logic [3:0]     w_rise;
  logic [3:0]     w_rep;
  logic [3:0]     r_pulse;
  logic           r_giro;
  logic           w_tb;
  logic [LW-1:0]  r_hold_cnt;
  logic           w_long_hit;
  logic           w_short_rel;
  t_state_e       r_state;
  logic           r_botonTest;
  logic [3:0]     r_bpulse;
  logic [3:0]     r_sel;
  logic [HW-1:0]  r_exit_cnt;

  // Bit order: sleep, awake, feed, play, test, giro; all normalised to pressed/active = 1.
  assign w_raw = {giro_raw, ~btn_test_n, ~btn_play_n, ~btn_feed_n, ~btn_awake_n, ~btn_sleep_n};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar g;
  generate
    for (g = 0; g < NIN; g++) begin : g_db
      logic [DW-1:0] r_cnt;
      logic          r_lvl;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt <= '0;
          r_lvl <= 1'b0;
        end else if (r_sync2[g] == r_lvl) begin
          r_cnt <= '0;
        end else if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_cnt <= '0;
          r_lvl <= r_sync2[g];
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end
      assign w_deb[g] = r_lvl;
    end
  endgenerate

  assign w_rise = w_deb[3:0] & ~r_deb_d;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;

  assign w_rep[1:0] = 2'b00;
  generate
    for (g = 2; g < 4; g++) begin : g_rep
      logic [RW-1:0] r_rcnt;
      logic          w_due;
      assign w_due    = (r_rcnt == RW'(REPEAT_CYCLES - 1));
      assign w_rep[g] = w_deb[g] & ~r_botonTest & ~w_rise[g] & w_due;
      // Phase is anchored on the initial pulse, so repeats land at +REPEAT_CYCLES multiples.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_rcnt <= '0;
        end else if (!w_deb[g] || r_botonTest || w_rise[g] || w_due) begin
          r_rcnt <= '0;
        end else begin
          r_rcnt <= r_rcnt + RW'(1);
        end
      end
    end
  endgenerate
`else
  assign w_rep = 4'b0000;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb_d <= '0;
      r_pulse <= '0;
      r_giro  <= 1'b0;
    end else begin
      r_deb_d <= w_deb[3:0];
      r_pulse <= r_botonTest ? 4'b0000 : (w_rise | w_rep);
      r_giro  <= w_deb[5];
    end
  end

  assign w_tb        = w_deb[4];
  assign w_long_hit  = w_tb && (r_hold_cnt == LW'(LONG_PRESS_CYCLES - 1));
  // hold_cnt still carries the press length on the first released cycle.
  assign w_short_rel = !w_tb && (r_hold_cnt != '0) && (r_hold_cnt != LW'(LONG_PRESS_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_cnt <= '0;
    end else if (!w_tb) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != LW'(LONG_PRESS_CYCLES)) begin
      r_hold_cnt <= r_hold_cnt + LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= T_OFF;
      r_botonTest <= 1'b0;
      r_bpulse    <= 4'd0;
      r_sel       <= 4'd0;
      r_exit_cnt  <= '0;
    end else begin
      case (r_state)
        T_OFF: begin
          if (w_long_hit) begin
            r_state     <= T_ENTER_WAIT;
            r_sel       <= 4'd0;
            r_botonTest <= 1'b1;
          end
        end
        T_ENTER_WAIT: begin
          if (!w_tb) r_state <= T_SEL;
        end
        T_SEL: begin
          if (w_long_hit) begin
            r_state     <= T_EXIT;
            r_botonTest <= 1'b0;
            r_bpulse    <= (r_sel == 4'd0) ? 4'd1 : r_sel;
            r_exit_cnt  <= '0;
          end else if (w_short_rel) begin
            r_sel <= (r_sel == 4'(SEL_MAX)) ? 4'd1 : r_sel + 4'd1;
          end
        end
        T_EXIT: begin
          if (r_exit_cnt == HW'(HOLD_CYCLES - 1)) begin
            r_bpulse <= 4'd0;
            r_state  <= T_EXIT_WAIT;
          end else begin
            r_exit_cnt <= r_exit_cnt + HW'(1);
          end
        end
        T_EXIT_WAIT: begin
          if (!w_tb) r_state <= T_OFF;
        end
        default: begin
          r_state     <= T_OFF;
          r_botonTest <= 1'b0;
          r_bpulse    <= 4'd0;
        end
      endcase
    end
  end

  assign botonSleep = r_pulse[0];
  assign botonAwake = r_pulse[1];
  assign botonFeed  = r_pulse[2];
  assign botonPlay  = r_pulse[3];
  assign giro       = r_giro;
  assign botonTest  = r_botonTest;
  assign BpulseTest = r_bpulse;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short debounce/long-press/hold/repeat parameters.
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn_n;      // {test, play, feed, awake, sleep}, active-low
  logic       giro_raw;
  logic       botonSleep, botonAwake, botonFeed, botonPlay, giro, botonTest;
  logic [3:0] BpulseTest;

  int checks   = 0;
  int failures = 0;

`ifdef BTN_AUTOREPEAT_EN
  localparam int S1_PCNT  = 2;
  localparam int S1_PLAST = 27;
  localparam int LP_PCNT  = 4;
  localparam int LP_PLAST = 67;
`else
  localparam int S1_PCNT  = 1;
  localparam int S1_PLAST = 7;
  localparam int LP_PCNT  = 1;
  localparam int LP_PLAST = 7;
`endif

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(40),
    .SEL_MAX          (9),
    .HOLD_CYCLES      (5),
    .REPEAT_CYCLES    (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_sleep_n(btn_n[0]),
    .btn_awake_n(btn_n[1]),
    .btn_feed_n (btn_n[2]),
    .btn_play_n (btn_n[3]),
    .btn_test_n (btn_n[4]),
    .giro_raw   (giro_raw),
    .botonSleep (botonSleep),
    .botonAwake (botonAwake),
    .botonFeed  (botonFeed),
    .botonPlay  (botonPlay),
    .giro       (giro),
    .botonTest  (botonTest),
    .BpulseTest (BpulseTest)
  );

  typedef struct {
    logic [4:0]      btn_n;
    logic            giro;
    int              len;
    logic [3:0][7:0] cnt;
    logic [3:0][7:0] first;
    logic [3:0][7:0] last;
    int              gchg;
  } seg_t;

  localparam int NSEG = 21;
  seg_t segs[NSEG];

  function automatic seg_t mk(input logic [4:0] b, input logic gv, input int len,
                              input logic [3:0] pmask, input int first,
                              input int pcnt, input int plast, input int gchg);
    seg_t s;
    s.btn_n = b;
    s.giro  = gv;
    s.len   = len;
    s.gchg  = gchg;
    for (int i = 0; i < 4; i++) begin
      s.cnt[i]   = 8'd0;
      s.first[i] = 8'd0;
      s.last[i]  = 8'd0;
      if (pmask[i]) begin
        s.cnt[i]   = (i == 3) ? 8'(pcnt) : 8'd1;
        s.first[i] = 8'(first);
        s.last[i]  = (i == 3) ? 8'(plast) : 8'(first);
      end
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic run_seg(input int idx);
    seg_t       s;
    int         c[4];
    int         f[4];
    int         l[4];
    logic [3:0] p;
    logic       g0;
    int         gc;
    s        = segs[idx];
    btn_n    = s.btn_n;
    giro_raw = s.giro;
    g0       = giro;
    gc       = 0;
    for (int i = 0; i < 4; i++) begin
      c[i] = 0; f[i] = 0; l[i] = 0;
    end
    for (int k = 1; k <= s.len; k++) begin
      tick();
      p = {botonPlay, botonFeed, botonAwake, botonSleep};
      for (int i = 0; i < 4; i++) begin
        if (p[i]) begin
          c[i]++;
          if (f[i] == 0) f[i] = k;
          l[i] = k;
        end
      end
      if (gc == 0 && giro != g0) gc = k;
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seg%0d_out%0d_count", idx, i), c[i], int'(s.cnt[i]));
      chk($sformatf("seg%0d_out%0d_first", idx, i), f[i], int'(s.first[i]));
      chk($sformatf("seg%0d_out%0d_last", idx, i), l[i], int'(s.last[i]));
    end
    chk($sformatf("seg%0d_giro_change", idx), gc, s.gchg);
  endtask

  // 50-cycle test-button hold, then release; observes the 40-cycle long-press boundary.
  task automatic long_press(input string tag, input logic entering, input int exp_bp);
    btn_n[4] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 45) begin
        chk({tag, "_test_c45"}, botonTest, entering ? 0 : 1);
        chk({tag, "_bp_c45"}, BpulseTest, 0);
      end
      if (k == 46) begin
        chk({tag, "_test_c46"}, botonTest, entering ? 1 : 0);
        chk({tag, "_bp_c46"}, BpulseTest, entering ? 0 : exp_bp);
      end
      if (k == 50) begin
        chk({tag, "_bp_c50"}, BpulseTest, entering ? 0 : exp_bp);
        btn_n[4] = 1'b1;
      end
      if (k == 51) chk({tag, "_bp_c51"}, BpulseTest, 0);
      if (k == 60) chk({tag, "_test_c60"}, botonTest, entering ? 1 : 0);
    end
  endtask

  task automatic short_presses(input string tag, input int n);
    for (int j = 0; j < n; j++) begin
      btn_n[4] = 1'b0;
      repeat (10) tick();
      btn_n[4] = 1'b1;
      repeat (10) tick();
    end
    chk({tag, "_test_after_sel"}, botonTest, 1);
    chk({tag, "_bp_after_sel"}, BpulseTest, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nf;

    segs[0]  = mk(5'b11111, 1'b0, 10, 4'b0000, 0, 0, 0, 0);
    segs[1]  = mk(5'b10110, 1'b0, 30, 4'b1001, 7, S1_PCNT, S1_PLAST, 0);
    segs[2]  = mk(5'b11111, 1'b0, 20, 4'b0000, 0, 0, 0, 0);
    segs[3]  = mk(5'b11101, 1'b0, 12, 4'b0010, 7, 0, 0, 0);
    segs[4]  = mk(5'b11111, 1'b0, 12, 4'b0000, 0, 0, 0, 0);
    segs[5]  = mk(5'b11111, 1'b1, 15, 4'b0000, 0, 0, 0, 7);
    segs[6]  = mk(5'b11111, 1'b0, 15, 4'b0000, 0, 0, 0, 7);
    for (int j = 0; j < 10; j++)
      segs[7 + j] = mk((j % 2 == 0) ? 5'b11011 : 5'b11111, 1'b0, 2, 4'b0000, 0, 0, 0, 0);
    segs[17] = mk(5'b11011, 1'b0, 30, 4'b0100, 7, 0, 0, 0);
    segs[18] = mk(5'b11111, 1'b0, 20, 4'b0000, 0, 0, 0, 0);
    segs[19] = mk(5'b10111, 1'b0, 70, 4'b1000, 7, LP_PCNT, LP_PLAST, 0);
    segs[20] = mk(5'b11111, 1'b0, 20, 4'b0000, 0, 0, 0, 0);

    rst      = 1'b1;
    btn_n    = 5'b11111;
    giro_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sleep", botonSleep, 0);
    chk("reset_awake", botonAwake, 0);
    chk("reset_feed", botonFeed, 0);
    chk("reset_play", botonPlay, 0);
    chk("reset_giro", giro, 0);
    chk("reset_test", botonTest, 0);
    chk("reset_bpulse", BpulseTest, 0);
    rst = 1'b0;

    for (int i = 0; i < NSEG; i++) run_seg(i);

    long_press("sel3_enter", 1'b1, 0);
    short_presses("sel3", 3);
    long_press("sel3_exit", 1'b0, 3);

    long_press("wrap_enter", 1'b1, 0);
    short_presses("wrap", 10);
    long_press("wrap_exit", 1'b0, 1);

    long_press("zero_enter", 1'b1, 0);
    long_press("zero_exit", 1'b0, 1);

    long_press("mask_enter", 1'b1, 0);
    btn_n[2] = 1'b0;
    nf = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if (botonFeed) nf++;
    end
    chk("mask_feed_pulses", nf, 0);
    btn_n[2] = 1'b1;
    repeat (15) tick();
    long_press("mask_exit", 1'b0, 1);

    giro_raw = 1'b1;
    long_press("rst_enter", 1'b1, 0);
    btn_n[4] = 1'b0;
    repeat (20) tick();
    chk("pre_rst_test", botonTest, 1);
    chk("pre_rst_giro", giro, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_test", botonTest, 0);
    chk("rst_mid_bpulse", BpulseTest, 0);
    chk("rst_mid_giro", giro, 0);
    chk("rst_mid_pulses", {botonPlay, botonFeed, botonAwake, botonSleep}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    long_press("rst_fresh_enter", 1'b1, 0);
    long_press("rst_fresh_exit", 1'b0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Upstream front end for the pet control FSM. It takes the raw board push-buttons and the rotation switch, synchronises and debounces them, and drives the FSM's button inputs.
- Sleep/awake/feed/play presses become single-cycle pulses.
- A long press on the test button enters and leaves test mode. Short presses while in test mode select the 1..9 scenario code consumed as `BpulseTest`.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz).
- LONG_PRESS_CYCLES, 250000000, debounced-held cycles that make a long press (5 s).
- SEL_MAX, 9, highest scenario code; selection wraps SEL_MAX -> 1.
- HOLD_CYCLES, 50, cycles `BpulseTest` stays valid after test-mode exit.
- REPEAT_CYCLES, 25000000, auto-repeat period (optional feature only).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_sleep_n  in  1  raw sleep button, active-low
- btn_awake_n  in  1  raw awake button, active-low
- btn_feed_n  in  1  raw feed button, active-low
- btn_play_n  in  1  raw play button, active-low
- btn_test_n  in  1  raw test button, active-low
- giro_raw  in  1  raw rotation/tilt switch, active-high
- botonSleep  out  1  one-cycle press pulse
- botonAwake  out  1  one-cycle press pulse
- botonFeed  out  1  one-cycle press pulse
- botonPlay  out  1  one-cycle press pulse
- giro  out  1  debounced level of giro_raw
- botonTest  out  1  high while test mode is active
- BpulseTest  out  4  scenario code; 0 = none

Behaviour:
- Reset: all outputs 0. Every debounced state = released (giro = 0), all counters 0, test FSM = T_OFF, sel = 0. Reset mid-press aborts everything. A button still held when reset is released is treated as a new press after debounce.
- Input path: 2-FF synchroniser per input, active-low inverted to pressed = 1. Then a per-input debounce counter:
  - counts while the synchronised value differs from the debounced value;
  - the debounced value flips when the count reaches DEBOUNCE_CYCLES;
  - any cycle of agreement clears the counter.
- Pulses: `botonSleep`/`botonAwake`/`botonFeed`/`botonPlay` assert for exactly 1 cycle, registered, on the cycle after the debounced rise.
  - Latency from raw edge: 2 + DEBOUNCE_CYCLES + 1 cycles.
  - Release never pulses.
  - Simultaneous presses pulse independently in the same cycle.
  - All four pulses are masked to 0 while `botonTest` = 1.
- giro: debounced level, registered, same latency. Never masked.
- Test FSM (driven by the debounced test button, tb). hold_cnt saturates at LONG_PRESS_CYCLES and clears whenever tb = 0.
  - T_OFF: `botonTest` = 0.
    - tb held until hold_cnt reaches LONG_PRESS_CYCLES -> T_ENTER_WAIT, sel = 0, `botonTest` = 1 from the next cycle.
    - A short press does nothing.
  - T_ENTER_WAIT: `botonTest` = 1. Wait for tb = 0 -> T_SEL. This release does not count as a selection.
  - T_SEL: `botonTest` = 1.
    - A press released before LONG_PRESS_CYCLES increments sel on the release cycle, wrapping SEL_MAX -> 1.
    - A press reaching LONG_PRESS_CYCLES -> T_EXIT.
  - T_EXIT: `botonTest` = 0.
    - `BpulseTest` = sel, or 1 if sel = 0. It becomes valid the same cycle `botonTest` falls and is held HOLD_CYCLES cycles.
    - Then `BpulseTest` = 0 -> T_EXIT_WAIT.
  - T_EXIT_WAIT: wait for tb = 0 -> T_OFF. This prevents the exit press from re-arming test mode.
- `BpulseTest` is 0 in every state except T_EXIT.
- A raw test-button bounce shorter than DEBOUNCE_CYCLES never affects sel.
- Counters are sized with $clog2 of their parameter. No counter wraps except sel.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - While feed or play stays debounced-pressed, a further pulse is emitted every REPEAT_CYCLES after the initial pulse.
  - The first repeat comes REPEAT_CYCLES after the first pulse.
  - Repeats stop on release or when `botonTest` = 1.
  - Sleep and awake never repeat.
- Undefined: exactly one pulse per press; REPEAT_CYCLES is unused.

Test Plan:
- Bench parameters for all scenarios: DEBOUNCE_CYCLES = 4, LONG_PRESS_CYCLES = 40, HOLD_CYCLES = 5, REPEAT_CYCLES = 20.
- Bounce rejection: btn_feed_n toggles low/high every 2 cycles for 20 cycles, then stays low -> exactly one `botonFeed` pulse, 7 cycles after the final stable low edge.
- Simultaneous press: btn_sleep_n and btn_play_n low on the same cycle for 30 cycles -> `botonSleep` and `botonPlay` each pulse once, both on cycle 7; no pulse on release.
- Test entry/select/exit:
  - btn_test_n low 50 cycles -> `botonTest` = 1.
  - Release, then 3 short presses (10 cycles low / 10 high each) -> sel = 3.
  - Hold 50 cycles -> `botonTest` = 0 and `BpulseTest` = 3 for 5 cycles, then 0.
- Wrap and zero-select:
  - 10 short presses in test mode -> `BpulseTest` = 1 on exit.
  - Entry followed by immediate long exit -> `BpulseTest` = 1.
- Masking and reset:
  - Feed press while `botonTest` = 1 -> no `botonFeed` pulse.
  - rst asserted during T_SEL -> all outputs 0 immediately; a held test button after reset needs a fresh 40-cycle hold to enter test mode.
- BTN_AUTOREPEAT_EN:
  - Hold btn_play_n low 70 cycles -> pulses at cycles 7, 27, 47, 67.
  - With the macro undefined, the same stimulus gives only the cycle-7 pulse.
